// File: rtl/switch_box_config_loader.sv
// Word-serial configuration loader for one universal_switch_box tile.
// Words fill a shadow register; a trailing XOR checksum gates an atomic commit to c.
module switch_box_config_loader #(
  parameter int WS = 8,
  parameter int WD = 8,
  parameter int CW = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic [CW-1:0]                 cfg_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  output logic [WS*6 + WD/2*6 - 1:0]    c,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int CFGW = WS*6 + WD/2*6;
  localparam int NW   = (CFGW + CW - 1) / CW;
  localparam int SHW  = NW * CW;
  localparam int CNTW = $clog2(NW + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(NW);

  // Handshake: a word transfers on a rising edge where cfg_valid && cfg_ready;
  // cfg_ready is a registered decode of LOAD and never depends on cfg_valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   chk;
  // Padded to whole words; bits above CFGW still feed acc but never reach c.
  logic [SHW-1:0]  shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      chk       <= '0;
      shadow    <= '0;
      c         <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= LOAD;
            cnt       <= '0;
            acc       <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            // Restart wins over a word offered in the same cycle; shadow is kept.
            cnt <= '0;
            acc <= '0;
          end else if (cfg_valid && cfg_ready) begin
            if (cnt == LAST) begin
              chk       <= cfg_data;
              state     <= CHECK;
              cfg_ready <= 1'b0;
            end else begin
              for (int k = 0; k < NW; k++) begin
                if (cnt == CNTW'(k)) shadow[k*CW +: CW] <= cfg_data;
              end
              acc <= acc ^ cfg_data;
              cnt <= cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          if (chk == acc) begin
            c    <= shadow[CFGW-1:0];
            done <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Bench for switch_box_config_loader: word-queue reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_switch_box_config_loader;

  localparam int WS   = 8;
  localparam int WD   = 8;
  localparam int CW   = 8;
  localparam int CFGW = WS*6 + WD/2*6;
  localparam int NW   = (CFGW + CW - 1) / CW;
  localparam logic [CFGW-1:0] NOMINAL_C = 72'h090807060504030201;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_start = 1'b0;
  logic [CW-1:0]   cfg_data = '0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CFGW-1:0] c;
  logic            busy;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;

  switch_box_config_loader #(.WS(WS), .WD(WD), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CFGW-1:0] act, input logic [CFGW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A load is just the list of accepted words; the last one is the checksum.
  logic [CFGW-1:0] m_c = '0;
  int              m_phase = 0;   // 0 idle, 1 taking words, 2 deciding
  logic            m_done = 1'b0;
  logic            m_err = 1'b0;
  logic [CW-1:0]   m_words[$];

  always @(posedge clk) begin
    logic [CW-1:0] x;
    if (rst) begin
      m_c = '0; m_phase = 0; m_done = 1'b0; m_err = 1'b0;
      m_words.delete();
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      case (m_phase)
        0: if (cfg_start) begin m_phase = 1; m_words.delete(); end
        1: begin
          if (cfg_start) m_words.delete();
          else if (cfg_valid) begin
            m_words.push_back(cfg_data);
            if (m_words.size() == NW + 1) m_phase = 2;
          end
        end
        default: begin
          x = '0;
          for (int k = 0; k < NW; k++) x ^= m_words[k];
          if (x == m_words[NW]) begin
            for (int k = 0; k < NW; k++) m_c[k*CW +: CW] = m_words[k];
            m_done = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_phase = 0;
        end
      endcase
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  logic chk_en = 1'b0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic [CFGW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("c",         c,                 m_c);
      check("cfg_ready", CFGW'(cfg_ready),  CFGW'(m_phase == 1));
      check("busy",      CFGW'(busy),       CFGW'(m_phase != 0));
      check("done",      CFGW'(done),       CFGW'(m_done));
      check("err",       CFGW'(err),        CFGW'(m_err));
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) check("unexpected_commit", c, '1);
        else check("commit_value", c, exp_q.pop_front());
      end
      if (err) err_cnt++;
    end
    // Inputs are stable from here to the next rising edge, so this is a real transfer.
    if (!rst && cfg_valid && cfg_ready && !cfg_start) hs_cnt++;
  end

  // ---------------- driver tasks (all start and end at a falling edge) ----------------
  task automatic do_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [CW-1:0] d);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", CFGW'(cfg_ready), CFGW'(1));
    @(negedge clk);
  endtask

  task automatic gap();
    cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [CW-1:0] w[NW], input logic [CW-1:0] cs, input bit stall);
    do_start();
    for (int k = 0; k < NW; k++) begin
      send_word(w[k]);
      if (stall) gap();
    end
    send_word(cs);
    gap();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [CW-1:0] nom[NW];
  logic [CW-1:0] pat[NW];
  logic [CW-1:0] pat_cs;

  initial begin
    for (int k = 0; k < NW; k++) nom[k] = CW'(k + 1);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_c",     c,               '0);
    check("rst_ready", CFGW'(cfg_ready), '0);
    check("rst_busy",  CFGW'(busy),      '0);
    check("rst_done",  CFGW'(done),      '0);
    check("rst_err",   CFGW'(err),       '0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Nominal load: done one cycle after checksum, busy falls that same cycle
    done_cnt = 0;
    exp_q.push_back(NOMINAL_C);
    do_start();
    for (int k = 0; k < NW; k++) send_word(nom[k]);
    cfg_valid = 1'b1;
    cfg_data  = 8'h01;
    @(negedge clk);              // checksum transferred at the edge just passed: CHECK now
    cfg_valid = 1'b0;
    check("nom_busy_in_check", CFGW'(busy), CFGW'(1));
    check("nom_c_not_yet",     c,           '0);
    @(negedge clk);
    check("nom_c",         c,           NOMINAL_C);
    check("nom_done",      CFGW'(done), CFGW'(1));
    check("nom_busy_fell", CFGW'(busy), '0);
    check("model_c_pin",   m_c,         NOMINAL_C);
    @(negedge clk);
    check("nom_done_pulse", CFGW'(done), '0);
    check("nom_done_cnt",   CFGW'(done_cnt), CFGW'(1));

    // Bad checksum after a good load: err, c held
    err_cnt = 0; done_cnt = 0;
    load(nom, 8'h00, 1'b0);
    check("bad_err_cnt",  CFGW'(err_cnt),  CFGW'(1));
    check("bad_done_cnt", CFGW'(done_cnt), '0);
    check("bad_c_held",   c,               NOMINAL_C);

    // Distinct pattern with a bench-computed checksum
    pat_cs = '0;
    for (int k = 0; k < NW; k++) begin
      pat[k] = CW'((k * 37 + 90) & 8'hFF);
      pat_cs ^= pat[k];
    end
    exp_q.push_back({pat[8], pat[7], pat[6], pat[5], pat[4], pat[3], pat[2], pat[1], pat[0]});
    done_cnt = 0;
    load(pat, pat_cs, 1'b0);
    check("pat_done_cnt", CFGW'(done_cnt), CFGW'(1));
    check("pat_c_byte0",  CFGW'(c[7:0]),   CFGW'(8'h5A));

    // Stall: valid low every other cycle
    hs_cnt = 0; done_cnt = 0;
    exp_q.push_back(NOMINAL_C);
    load(nom, 8'h01, 1'b1);
    check("stall_c",        c,               NOMINAL_C);
    check("stall_handshakes", CFGW'(hs_cnt), CFGW'(10));
    check("stall_done_cnt", CFGW'(done_cnt), CFGW'(1));

    // Restart: 4 x 0xFF, restart with a word still offered, then a nominal load
    done_cnt = 0; err_cnt = 0;
    do_start();
    for (int k = 0; k < 4; k++) send_word(8'hFF);
    exp_q.push_back(NOMINAL_C);
    load(nom, 8'h01, 1'b0);
    check("restart_c",        c,               NOMINAL_C);
    check("restart_done_cnt", CFGW'(done_cnt), CFGW'(1));
    check("restart_err_cnt",  CFGW'(err_cnt),  '0);

    // Reset mid-load after a good load
    do_start();
    for (int k = 0; k < 5; k++) send_word(nom[k]);
    cfg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_c",     c,                '0);
    check("midrst_busy",  CFGW'(busy),      '0);
    check("midrst_ready", CFGW'(cfg_ready), '0);
    @(negedge clk);
    done_cnt = 0;
    exp_q.push_back(NOMINAL_C);
    load(nom, 8'h01, 1'b0);
    check("after_rst_c",        c,               NOMINAL_C);
    check("after_rst_done_cnt", CFGW'(done_cnt), CFGW'(1));
    check("exp_q_drained",      CFGW'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
